// File: rtl/wb_pkg.sv
// Shared definitions for the write-back buffer: drain FSM encoding and the
// default word geometry used by the cache map and RAM models.
package wb_pkg;
    localparam int WB_ADDR_W = 5;
    localparam int WB_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        WAIT  = 2'd2
    } wb_state_t;
endpackage

// File: rtl/writeback_buffer_if.sv
// Evict / RAM-write / probe bundle between the cache controller, the
// write-back buffer and main RAM.
interface writeback_buffer_if
    import wb_pkg::*;
#(
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DATA_W = WB_DATA_W,
    parameter int CNT_W  = 2
);
    logic              evict_valid;
    logic              evict_ready;
    logic [ADDR_W-1:0] evict_addr;
    logic [DATA_W-1:0] evict_data;
    logic              mem_wren;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [ADDR_W-1:0] probe_addr;
    logic              probe_hit;
    logic [DATA_W-1:0] probe_data;
    logic              flush;
    logic [CNT_W-1:0]  count;
    logic              idle;

    // Buffer side
    modport slave (
        input  evict_valid, evict_addr, evict_data, mem_ack, probe_addr, flush,
        output evict_ready, mem_wren, mem_addr, mem_wdata, probe_hit, probe_data,
               count, idle
    );

    // Cache controller / RAM side
    modport master (
        output evict_valid, evict_addr, evict_data, mem_ack, probe_addr, flush,
        input  evict_ready, mem_wren, mem_addr, mem_wdata, probe_hit, probe_data,
               count, idle
    );
endinterface

// File: rtl/wb_match.sv
// Address comparator over all buffer entries. Produces the raw match vector
// and the index of the newest matching entry (the one closest to tail).
module wb_match #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 5,
    parameter int PTR_W  = 1
) (
    input  logic [DEPTH-1:0]             valid,
    input  logic [DEPTH-1:0][ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0]            key,
    input  logic [PTR_W-1:0]             head,
    output logic [DEPTH-1:0]             match,
    output logic [PTR_W-1:0]             sel
);
    // Per-entry compare
    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++)
            match[i] = valid[i] && (addr[i] == key);
    end

    // Walk from oldest (head) to newest; the last match seen wins
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx = '0;
        sel = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (match[idx]) sel = idx;
        end
    end
endmodule

// File: rtl/writeback_buffer.sv
// Write-back buffer: small coalescing FIFO of evicted words drained to RAM
// one write at a time, with a combinational probe for the refill path.
module writeback_buffer
    import wb_pkg::*;
#(
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DATA_W = WB_DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic               clock,
    input  logic               reset,
    writeback_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]             ent_vld;
    logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
    logic [DEPTH-1:0][DATA_W-1:0] ent_data;
    logic [PTR_W-1:0]             head, tail;
    logic [CNT_W-1:0]             count_q;
    wb_state_t                    state, state_nx;

    logic             launch, pop, xfer, coal, alloc, head_in_flight;
    logic [DEPTH-1:0] head_oh, coal_vld, c_match, p_match;
    logic [PTR_W-1:0] c_sel, p_sel;

    assign launch         = (state == IDLE) && (count_q != '0);
    assign pop            = (state == WAIT) && bus.mem_ack;
    assign head_in_flight = (state != IDLE);
    assign head_oh        = DEPTH'(1) << head;
    // The in-flight head is not a coalescing target: its write is already on the bus
    assign coal_vld       = ent_vld & ~(head_in_flight ? head_oh : '0);

    assign bus.evict_ready = (count_q < CNT_W'(DEPTH)) && !bus.flush;
    assign xfer            = bus.evict_valid && bus.evict_ready;
    assign coal            = xfer && (|c_match);
    assign alloc           = xfer && !(|c_match);

    wb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .PTR_W(PTR_W)) u_coal_match (
        .valid(coal_vld), .addr(ent_addr), .key(bus.evict_addr), .head(head),
        .match(c_match), .sel(c_sel)
    );

    wb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .PTR_W(PTR_W)) u_probe_match (
        .valid(ent_vld), .addr(ent_addr), .key(bus.probe_addr), .head(head),
        .match(p_match), .sel(p_sel)
    );

    assign bus.probe_hit  = |p_match;
    assign bus.probe_data = (|p_match) ? ent_data[p_sel] : '0;
    assign bus.count      = count_q;
    assign bus.idle       = (count_q == '0) && (state == IDLE);

    // Drain FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Drain FSM next state; ack during WRITE is ignored by construction
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (count_q != '0) state_nx = WRITE;
            WRITE:   state_nx = WAIT;
            WAIT:    if (bus.mem_ack) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Entry storage, pointers and occupancy
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ent_vld  <= '0;
            ent_addr <= '0;
            ent_data <= '0;
            head     <= '0;
            tail     <= '0;
            count_q  <= '0;
        end else begin
            if (pop) begin
                ent_vld[head] <= 1'b0;
                head          <= head + 1'b1;
            end
            if (coal) ent_data[c_sel] <= bus.evict_data;
            if (alloc) begin
                ent_vld[tail]  <= 1'b1;
                ent_addr[tail] <= bus.evict_addr;
                ent_data[tail] <= bus.evict_data;
                tail           <= tail + 1'b1;
            end
            count_q <= count_q + CNT_W'(alloc) - CNT_W'(pop);
        end
    end

    // RAM write port; a coalesce into the head on its launch edge is
    // forwarded so the issued write carries the newest data
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.mem_wren  <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_wren <= launch;
            if (launch) begin
                bus.mem_addr  <= ent_addr[head];
                bus.mem_wdata <= (coal && (c_sel == head)) ? bus.evict_data
                                                          : ent_data[head];
            end
        end
    end
endmodule

// File: tb/tb_writeback_buffer.sv
// Bench for writeback_buffer: directed scenarios followed by random traffic,
// each cycle checked against a queue-based model of the buffer.
module tb_writeback_buffer;
    localparam int DEPTH = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    writeback_buffer_if #(.ADDR_W(5), .DATA_W(8), .CNT_W(2)) bus ();

    writeback_buffer #(.ADDR_W(5), .DATA_W(8), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    typedef struct packed { logic [4:0] a; logic [7:0] d; } ent_t;

    // Model: oldest-first queue of buffered words plus the outstanding RAM write
    ent_t       q[$];
    bit         busy;        // a write has been issued and not yet acknowledged
    int         since;       // edges elapsed since that write was issued
    bit         m_wren;
    logic [4:0] m_addr;
    logic [7:0] m_data;

    int tests = 0;
    int fails = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        busy = 0; since = 0;
        m_wren = 0; m_addr = '0; m_data = '0;
    endtask

    // One clock: drive inputs, check combinational outputs, advance model, check registers
    task automatic step(bit v, logic [4:0] a, logic [7:0] d, bit ack, bit fl, logic [4:0] pa);
        bit         e_ready, e_hit, launch, accept, xfer;
        logic [7:0] e_pd;
        int         found;
        bus.evict_valid = v; bus.evict_addr = a; bus.evict_data = d;
        bus.mem_ack = ack; bus.flush = fl; bus.probe_addr = pa;
        #1;
        e_ready = (q.size() < DEPTH) && !fl;
        e_hit = 0; e_pd = '0;
        foreach (q[i]) if (q[i].a == pa) begin e_hit = 1; e_pd = q[i].d; end
        chk("evict_ready", bus.evict_ready, e_ready);
        chk("probe_hit", bus.probe_hit, e_hit);
        chk("probe_data", bus.probe_data, e_pd);

        launch = !busy && (q.size() != 0);
        accept = busy && (since >= 1) && ack;
        xfer   = v && e_ready;
        found  = -1;
        if (xfer)
            for (int i = (busy ? 1 : 0); i < q.size(); i++)
                if (q[i].a == a) found = i;
        if (found >= 0) q[found].d = d;
        m_wren = 0;
        if (launch) begin
            m_wren = 1; m_addr = q[0].a; m_data = q[0].d;
            busy = 1; since = 0;
        end else if (busy) begin
            if (accept) begin void'(q.pop_front()); busy = 0; end
            else since++;
        end
        if (xfer && found < 0) q.push_back('{a: a, d: d});

        @(posedge clock); #1;
        chk("count", bus.count, q.size());
        chk("mem_wren", bus.mem_wren, m_wren);
        chk("mem_addr", bus.mem_addr, m_addr);
        chk("mem_wdata", bus.mem_wdata, m_data);
        chk("idle", bus.idle, (q.size() == 0) && !busy);
    endtask

    task automatic probe_chk(logic [4:0] pa, bit hit, logic [7:0] data);
        bus.probe_addr = pa;
        #1;
        chk("probe_hit_dir", bus.probe_hit, hit);
        chk("probe_data_dir", bus.probe_data, data);
    endtask

    initial begin
        bus.evict_valid = 0; bus.evict_addr = '0; bus.evict_data = '0;
        bus.mem_ack = 0; bus.flush = 0; bus.probe_addr = '0;
        model_reset();

        // Power-on reset state
        #3;
        chk("rst_count", bus.count, 0);
        chk("rst_wren", bus.mem_wren, 0);
        chk("rst_idle", bus.idle, 1);
        chk("rst_ready", bus.evict_ready, 1);
        chk("rst_hit", bus.probe_hit, 0);
        #9 reset = 1;
        @(posedge clock); #1;

        // Single word, ack two cycles after the write pulse
        step(1, 5'h03, 8'hA5, 0, 0, 5'h03);
        step(0, 0, 0, 0, 0, 5'h03);
        chk("w1_addr", bus.mem_addr, 5'h03);
        chk("w1_data", bus.mem_wdata, 8'hA5);
        step(0, 0, 0, 0, 0, 5'h03);
        step(0, 0, 0, 1, 0, 5'h03);
        chk("w1_idle", bus.idle, 1);

        // Fill the buffer, probe, refuse while full, accept after ack
        step(1, 5'h03, 8'h11, 0, 0, 0);
        step(1, 5'h07, 8'h22, 0, 0, 0);
        chk("full_ready", bus.evict_ready, 0);
        probe_chk(5'h07, 1, 8'h22);
        probe_chk(5'h09, 0, 8'h00);
        step(1, 5'h07, 8'h33, 0, 0, 5'h07);
        step(1, 5'h03, 8'h44, 0, 0, 5'h03);
        step(1, 5'h03, 8'h44, 1, 0, 5'h03);
        step(1, 5'h03, 8'h44, 0, 0, 5'h03);
        probe_chk(5'h03, 1, 8'h44);
        repeat (8) step(0, 0, 0, 1, 0, 5'h03);

        // Coalesce into a head that is being launched this cycle
        step(1, 5'h09, 8'h55, 0, 0, 5'h09);
        step(1, 5'h09, 8'h66, 0, 0, 5'h09);
        chk("coal_count", bus.count, 1);
        chk("coal_wdata", bus.mem_wdata, 8'h66);
        step(0, 0, 0, 0, 0, 5'h09);
        // Enqueue in the ack cycle
        step(1, 5'h0A, 8'h77, 1, 0, 5'h0A);
        chk("ackenq_count", bus.count, 1);
        step(0, 0, 0, 0, 0, 5'h0A);
        chk("ackenq_addr", bus.mem_addr, 5'h0A);
        repeat (4) step(0, 0, 0, 1, 0, 0);

        // Flush with evict_valid held: no enqueue, FIFO-order drain
        step(1, 5'h01, 8'hC1, 0, 0, 0);
        step(1, 5'h02, 8'hC2, 0, 0, 0);
        repeat (8) step(1, 5'h0B, 8'h88, 1, 1, 5'h0B);
        chk("flush_idle", bus.idle, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("flush_ready", bus.evict_ready, 1);

        // Reset mid-WAIT with two entries, then a stray ack
        step(1, 5'h04, 8'hD4, 0, 0, 0);
        step(1, 5'h05, 8'hD5, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        reset = 0;
        #1;
        model_reset();
        chk("mrst_count", bus.count, 0);
        chk("mrst_wren", bus.mem_wren, 0);
        chk("mrst_idle", bus.idle, 1);
        chk("mrst_ready", bus.evict_ready, 1);
        chk("mrst_hit", bus.probe_hit, 0);
        reset = 1;
        step(0, 0, 0, 1, 0, 5'h04);

        // Random traffic
        for (int n = 0; n < 800; n++)
            step($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), 8'($urandom),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                 5'($urandom_range(0, 7)));
        repeat (10) step(0, 0, 0, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
